// File: rtl/branch_predict_unit_if.sv
// Fetch/execute signal bundle for the branch predict unit.
// The unit itself takes the slave side; the core (or a bench) drives the master side.
interface branch_predict_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PERF_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc_F;
    logic [DATA_WIDTH-1:0] PCPlus4F;
    logic                  predict_taken_F;
    logic [DATA_WIDTH-1:0] predict_target_F;

    logic                  valid_E;
    logic [2:0]            PCsrcE;
    logic [DATA_WIDTH-1:0] pc_E;
    logic [DATA_WIDTH-1:0] PCPlus4E;
    logic [DATA_WIDTH-1:0] PCTargetE;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  eq;
    logic                  branch_predictE;

    logic [DATA_WIDTH-1:0] pc;
    logic                  Hazard_PCsrc;
    logic [PERF_WIDTH-1:0] branch_count;
    logic [PERF_WIDTH-1:0] mispredict_count;

    modport slave (
        input  pc_F, PCPlus4F, valid_E, PCsrcE, pc_E, PCPlus4E, PCTargetE,
               ALUResult, eq, branch_predictE,
        output predict_taken_F, predict_target_F, pc, Hazard_PCsrc,
               branch_count, mispredict_count
    );

    modport master (
        output pc_F, PCPlus4F, valid_E, PCsrcE, pc_E, PCPlus4E, PCTargetE,
               ALUResult, eq, branch_predictE,
        input  predict_taken_F, predict_target_F, pc, Hazard_PCsrc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Next-PC select: BHT of saturating counters plus tagged BTB, execute-stage
// resolution with mispredict redirect, and saturating performance counters.
module branch_predict_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_WIDTH   = 2,
    parameter int PERF_WIDTH  = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_unit_if.slave bus
);
    localparam int IDX       = $clog2(BHT_ENTRIES);
    localparam int TAG_WIDTH = DATA_WIDTH - IDX - 2;

    localparam logic [2:0] NEXT_PC  = 3'd0;
    localparam logic [2:0] EQ_TRUE  = 3'd1;
    localparam logic [2:0] EQ_FALSE = 3'd2;
    localparam logic [2:0] UC_JUMP  = 3'd3;
    localparam logic [2:0] JALR     = 3'd4;

    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

    logic [CTR_WIDTH-1:0]  ctr          [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] entry_valid;
    logic [TAG_WIDTH-1:0]  entry_tag    [BHT_ENTRIES];
    logic [DATA_WIDTH-1:0] entry_target [BHT_ENTRIES];
    logic [PERF_WIDTH-1:0] branch_cnt_q;
    logic [PERF_WIDTH-1:0] mispredict_cnt_q;

    logic [IDX-1:0]        idx_F;
    logic [TAG_WIDTH-1:0]  tag_F;
    logic [IDX-1:0]        idx_E;
    logic [TAG_WIDTH-1:0]  tag_E;
    logic                  hit_F;
    logic                  predict_taken;
    logic [DATA_WIDTH-1:0] predict_target;
    logic                  is_cond_E;
    logic                  taken_E;
    logic                  mispredict_E;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  unused_bits;

    assign idx_F = bus.pc_F[IDX+1:2];
    assign tag_F = bus.pc_F[DATA_WIDTH-1:IDX+2];
    assign idx_E = bus.pc_E[IDX+1:2];
    assign tag_E = bus.pc_E[DATA_WIDTH-1:IDX+2];

    // Lookup reads registered state, so a same-cycle update is not visible yet.
    assign hit_F          = !rst && entry_valid[idx_F] && (entry_tag[idx_F] == tag_F);
    assign predict_taken  = hit_F && ctr[idx_F][CTR_WIDTH-1];
    assign predict_target = hit_F ? entry_target[idx_F] : '0;

    assign is_cond_E    = bus.valid_E && !rst &&
                          ((bus.PCsrcE == EQ_TRUE) || (bus.PCsrcE == EQ_FALSE));
    assign taken_E      = (bus.PCsrcE == EQ_TRUE) ? bus.eq : !bus.eq;
    assign mispredict_E = is_cond_E && (taken_E != bus.branch_predictE);

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (bus.valid_E && !rst) begin
            case (bus.PCsrcE)
                EQ_TRUE, EQ_FALSE: begin
                    if (taken_E != bus.branch_predictE) begin
                        redirect    = 1'b1;
                        redirect_pc = taken_E ? bus.PCTargetE : bus.PCPlus4E;
                    end
                end
                UC_JUMP: begin
                    redirect    = 1'b1;
                    redirect_pc = bus.PCTargetE;
                end
                JALR: begin
                    redirect    = 1'b1;
                    redirect_pc = {bus.ALUResult[DATA_WIDTH-1:1], 1'b0};
                end
                NEXT_PC: redirect = 1'b0;
                default: redirect = 1'b0;
            endcase
        end
    end

    assign bus.predict_taken_F  = predict_taken;
    assign bus.predict_target_F = predict_target;
    assign bus.Hazard_PCsrc     = redirect;
    assign bus.pc               = redirect ? redirect_pc :
                                  (predict_taken ? predict_target : bus.PCPlus4F);
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;

    // Only conditional branches train the tables; not-taken leaves the BTB entry alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i]          <= CTR_INIT;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
            end
            entry_valid      <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (is_cond_E) begin
            if (taken_E) begin
                if (ctr[idx_E] != CTR_MAX) ctr[idx_E] <= ctr[idx_E] + 1'b1;
                entry_valid[idx_E]  <= 1'b1;
                entry_tag[idx_E]    <= tag_E;
                entry_target[idx_E] <= bus.PCTargetE;
            end else begin
                if (ctr[idx_E] != CTR_MIN) ctr[idx_E] <= ctr[idx_E] - 1'b1;
            end
            if (branch_cnt_q != PERF_MAX) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict_E && (mispredict_cnt_q != PERF_MAX))
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end

    assign unused_bits = ^{bus.pc_F[1:0], bus.pc_E[1:0], bus.ALUResult[0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a per-entry behavioural model of the predictor.
module tb_branch_predict_unit;
    localparam int DW       = 32;
    localparam int ENTRIES  = 16;
    localparam int LOGN     = 4;
    localparam int CW       = 2;
    localparam int PW       = 4;
    localparam int CTR_TOP  = (1 << CW) - 1;
    localparam int CTR_HALF = 1 << (CW - 1);
    localparam int PERF_TOP = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.DATA_WIDTH(DW), .PERF_WIDTH(PW)) bus ();

    branch_predict_unit #(
        .DATA_WIDTH (DW),
        .BHT_ENTRIES(ENTRIES),
        .CTR_WIDTH  (CW),
        .PERF_WIDTH (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one record per table slot, counters as plain integers.
    int          mCtr    [ENTRIES];
    bit          mValid  [ENTRIES];
    logic [31:0] mTag    [ENTRIES];
    logic [31:0] mTarget [ENTRIES];
    int          mBranches;
    int          mMispredicts;

    logic [31:0] obsPc, obsTarget;
    logic        obsRedir, obsTaken;
    logic [31:0] obsBc, obsMc;

    function automatic int idxOf(logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tagOf(logic [31:0] a);
        return a >> (LOGN + 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mCtr[i]    = CTR_HALF - 1;
            mValid[i]  = 1'b0;
            mTag[i]    = '0;
            mTarget[i] = '0;
        end
        mBranches    = 0;
        mMispredicts = 0;
    endtask

    task automatic modelUpdate();
        int  i;
        bit  taken;
        int  code;
        code = int'(bus.PCsrcE);
        if (rst) begin
            modelReset();
        end else if (bus.valid_E && (code == 1 || code == 2)) begin
            taken = (code == 1) ? bus.eq : !bus.eq;
            i = idxOf(bus.pc_E);
            if (taken) begin
                mCtr[i]    = (mCtr[i] < CTR_TOP) ? mCtr[i] + 1 : CTR_TOP;
                mValid[i]  = 1'b1;
                mTag[i]    = tagOf(bus.pc_E);
                mTarget[i] = bus.PCTargetE;
            end else begin
                mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
            end
            mBranches = (mBranches < PERF_TOP) ? mBranches + 1 : PERF_TOP;
            if (taken != bus.branch_predictE)
                mMispredicts = (mMispredicts < PERF_TOP) ? mMispredicts + 1 : PERF_TOP;
        end
    endtask

    function automatic bit modelPredicts(logic [31:0] a);
        int i;
        i = idxOf(a);
        return mValid[i] && (mTag[i] == tagOf(a)) && (mCtr[i] >= CTR_HALF);
    endfunction

    // One cycle: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic applyStimulus();
        logic [31:0] ePc, eTarget;
        bit          eTaken, eRedir, hit, taken;
        int          i, code;
        bus.PCPlus4F = bus.pc_F + 32'd4;
        bus.PCPlus4E = bus.pc_E + 32'd4;
        @(negedge clk);
        i       = idxOf(bus.pc_F);
        hit     = mValid[i] && (mTag[i] == tagOf(bus.pc_F));
        eTaken  = !rst && modelPredicts(bus.pc_F);
        eTarget = hit ? mTarget[i] : 32'd0;
        eRedir  = 1'b0;
        ePc     = eTaken ? eTarget : bus.PCPlus4F;
        code    = int'(bus.PCsrcE);
        if (!rst && bus.valid_E) begin
            if (code == 1 || code == 2) begin
                taken = (code == 1) ? bus.eq : !bus.eq;
                if (taken != bus.branch_predictE) begin
                    eRedir = 1'b1;
                    ePc    = taken ? bus.PCTargetE : bus.PCPlus4E;
                end
            end else if (code == 3) begin
                eRedir = 1'b1;
                ePc    = bus.PCTargetE;
            end else if (code == 4) begin
                eRedir = 1'b1;
                ePc    = bus.ALUResult & ~32'd1;
            end
        end
        obsPc     = bus.pc;
        obsRedir  = bus.Hazard_PCsrc;
        obsTaken  = bus.predict_taken_F;
        obsTarget = bus.predict_target_F;
        obsBc     = 32'(bus.branch_count);
        obsMc     = 32'(bus.mispredict_count);
        checkOutput("redirect", 64'(obsRedir), 64'(eRedir));
        checkOutput("next_pc", 64'(obsPc), 64'(ePc));
        checkOutput("predict_taken", 64'(obsTaken), 64'(eTaken));
        if (!rst) checkOutput("predict_target", 64'(obsTarget), 64'(eTarget));
        checkOutput("branch_count", 64'(obsBc), 64'(mBranches));
        checkOutput("mispredict_count", 64'(obsMc), 64'(mMispredicts));
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic setExec(input bit v, input int code, input logic [31:0] pcE,
                           input logic [31:0] tgt, input bit eqv, input bit bp);
        bus.valid_E         = v;
        bus.PCsrcE          = 3'(code);
        bus.pc_E            = pcE;
        bus.PCTargetE       = tgt;
        bus.eq              = eqv;
        bus.branch_predictE = bp;
    endtask

    function automatic logic [31:0] pickPc();
        logic [31:0] pool [5];
        int          sel;
        pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h180;
        pool[3] = 32'h104; pool[4] = 32'h2c0;
        sel = int'($urandom_range(0, 6));
        return (sel < 5) ? pool[sel] : ($urandom & 32'hFFFF_FFFC);
    endfunction

    initial begin
        bus.pc_F = 32'h100;
        bus.ALUResult = '0;
        setExec(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.PCPlus4F = 32'h104;
        bus.PCPlus4E = 32'h4;
        @(posedge clk);
        #1;
        modelReset();
        applyStimulus();
        rst = 1'b0;

        applyStimulus();
        checkOutput("reset_pc", 64'(obsPc), 64'h104);
        checkOutput("reset_taken", 64'(obsTaken), 64'h0);
        checkOutput("reset_target", 64'(obsTarget), 64'h0);

        setExec(1'b1, 1, 32'h100, 32'h80, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("first_mispredict_pc", 64'(obsPc), 64'h80);
        checkOutput("first_mispredict_redir", 64'(obsRedir), 64'h1);

        setExec(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("learned_taken", 64'(obsTaken), 64'h1);
        checkOutput("learned_pc", 64'(obsPc), 64'h80);
        checkOutput("learned_mc", 64'(obsMc), 64'h1);

        for (int k = 0; k < 5; k++) begin
            setExec(1'b1, 1, 32'h100, 32'h80, 1'b1, 1'b1);
            applyStimulus();
        end
        setExec(1'b1, 2, 32'h100, 32'h80, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("not_taken_pc", 64'(obsPc), 64'h104);
        setExec(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("still_taken", 64'(obsTaken), 64'h1);
        checkOutput("branch_count_7", 64'(obsBc), 64'd7);

        bus.pc_F = 32'h140;
        applyStimulus();
        checkOutput("alias_taken", 64'(obsTaken), 64'h0);
        checkOutput("alias_pc", 64'(obsPc), 64'h144);

        bus.ALUResult = 32'h203;
        setExec(1'b1, 4, 32'h300, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("jalr_pc", 64'(obsPc), 64'h202);
        checkOutput("jalr_redir", 64'(obsRedir), 64'h1);
        setExec(1'b0, 4, 32'h300, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("jalr_bubble_redir", 64'(obsRedir), 64'h0);
        checkOutput("jalr_bubble_pc", 64'(obsPc), 64'h144);
        checkOutput("jalr_no_count", 64'(obsBc), 64'd7);

        for (int k = 0; k < 13; k++) begin
            setExec(1'b1, 1, 32'h180, 32'h40, 1'(k % 2), 1'b1);
            applyStimulus();
        end
        setExec(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("branch_count_sat", 64'(obsBc), 64'd15);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.pc_F = pickPc();
            bus.ALUResult = $urandom;
            setExec($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), pickPc(),
                    $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'b0);
            bus.branch_predictE = $urandom_range(0, 1) ? modelPredicts(bus.pc_E) : 1'($urandom);
            applyStimulus();
        end
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            setExec(1'b1, 1, 32'h100, 32'h80, 1'b1, 1'b0);
            applyStimulus();
        end
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        bus.pc_F = 32'h100;
        setExec(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("post_reset_bc", 64'(obsBc), 64'd0);
        checkOutput("post_reset_mc", 64'(obsMc), 64'd0);
        checkOutput("post_reset_taken", 64'(obsTaken), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
